// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: fetch FSM states, reset vector, address helper.
// No logic of its own; pure declarations.
package instr_prefetch_queue_pkg;

    typedef enum logic [1:0] {
        PF_IDLE  = 2'd0,
        PF_FETCH = 2'd1,
        PF_ABORT = 2'd2
    } pf_state_e;

    localparam logic [15:0] PF_RESET_CS = 16'hFFFF;
    localparam logic [15:0] PF_RESET_IP = 16'h0000;

    // Real-mode physical address, wrapping at 1 MiB.
    function automatic logic [19:0] phys_addr(input logic [15:0] cs, input logic [15:0] ip);
        return {cs, 4'b0000} + {4'b0000, ip};
    endfunction

endpackage

// File: rtl/instr_prefetch_queue_byte_ring_buffer.sv
// Byte circular buffer, 2-wide push and 2-wide peek/pop; flush empties it in one cycle.
// Peek is combinational from state; caller never pushes beyond free space or pops beyond count.
module byte_ring_buffer #(
    parameter  int DEPTH = 6,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       push_cnt,
    input  logic [7:0]       push_dat0,
    input  logic [7:0]       push_dat1,
    input  logic [1:0]       pop_cnt,
    output logic [7:0]       peek_dat0,
    output logic [7:0]       peek_dat1,
    output logic [CNT_W-1:0] count
);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W+1:0] occ_next;

    // Pointer advance with explicit wrap, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
        logic [PTR_W:0] s;
        s = (PTR_W+1)'(p) + (PTR_W+1)'(n);
        if (s >= (PTR_W+1)'(DEPTH)) begin
            s = s - (PTR_W+1)'(DEPTH);
        end
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_cnt != 2'd0) begin
                mem_d[wr_ptr_q] = push_dat0;
            end
            if (push_cnt == 2'd2) begin
                mem_d[ptr_add(wr_ptr_q, 2'd1)] = push_dat1;
            end
            wr_ptr_d = ptr_add(wr_ptr_q, push_cnt);
            rd_ptr_d = ptr_add(rd_ptr_q, pop_cnt);
            count_d  = count_q - CNT_W'(pop_cnt) + CNT_W'(push_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign occ_next = (CNT_W+2)'(count_q) + (CNT_W+2)'(push_cnt) - (CNT_W+2)'(pop_cnt);

    // Fetches are only issued with space reserved, so this can only fire on a design bug.
    always @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (occ_next <= (CNT_W+2)'(DEPTH));
        end
    end

    assign peek_dat0 = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
    assign peek_dat1 = (count_q == '0) ? 8'h00 : mem_q[ptr_add(rd_ptr_q, 2'd1)];
    assign count     = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch sequencer + byte queue: reads 16-bit words at CS:IP, presents two head bytes to the decoder.
// Bytes visible the cycle after mem_ack; a fetch is issued only when its bytes are guaranteed room.
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter  int          DEPTH    = 6,
    parameter  logic [15:0] RESET_CS = PF_RESET_CS,
    parameter  logic [15:0] RESET_IP = PF_RESET_IP,
    localparam int          CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_new_ip,
    input  logic [15:0]      new_cs,
    input  logic [15:0]      new_ip,
    output logic [18:0]      mem_addr,
    output logic             mem_access,
    input  logic             mem_ack,
    input  logic [15:0]      mem_data,
    output logic [7:0]       rd_data0,
    output logic [7:0]       rd_data1,
    output logic [CNT_W-1:0] count,
    input  logic [1:0]       rd_count,
    output logic [15:0]      head_ip
);

    pf_state_e   state_q, state_d;
    logic [15:0] fetch_cs_q, fetch_cs_d;
    logic [15:0] fetch_ip_q, fetch_ip_d;
    logic [15:0] head_ip_q, head_ip_d;
    logic [18:0] mem_addr_q, mem_addr_d;

    logic [19:0]    phys;
    logic           odd;
    logic [1:0]     fetch_bytes;
    logic [1:0]     rc_eff;
    logic [1:0]     pop;
    logic [CNT_W:0] free_space;
    logic [1:0]     rb_push_cnt;
    logic [1:0]     rb_pop_cnt;
    logic           rb_flush;

    assign phys        = phys_addr(fetch_cs_q, fetch_ip_q);
    assign odd         = phys[0];
    assign fetch_bytes = odd ? 2'd1 : 2'd2;

    // Over-reads are clipped to what is queued; rd_count=3 acts as 2.
    assign rc_eff     = (rd_count == 2'd3) ? 2'd2 : rd_count;
    assign pop        = (CNT_W'(rc_eff) > count) ? count[1:0] : rc_eff;
    assign free_space = (CNT_W+1)'(DEPTH) - (CNT_W+1)'(count) + (CNT_W+1)'(pop);

    always_comb begin
        state_d     = state_q;
        fetch_cs_d  = fetch_cs_q;
        fetch_ip_d  = fetch_ip_q;
        head_ip_d   = head_ip_q + 16'(pop);
        mem_addr_d  = mem_addr_q;
        rb_push_cnt = 2'd0;
        rb_pop_cnt  = pop;
        rb_flush    = 1'b0;
        if (load_new_ip) begin
            rb_flush   = 1'b1;
            rb_pop_cnt = 2'd0;
            fetch_cs_d = new_cs;
            fetch_ip_d = new_ip;
            head_ip_d  = new_ip;
            // An unacked access must still complete on the bus; its data is dropped.
            if (state_q != PF_IDLE) begin
                state_d = mem_ack ? PF_IDLE : PF_ABORT;
            end
        end else begin
            case (state_q)
                PF_IDLE: begin
                    if (free_space >= (CNT_W+1)'(fetch_bytes)) begin
                        state_d    = PF_FETCH;
                        mem_addr_d = phys[19:1];
                    end
                end
                PF_FETCH: begin
                    if (mem_ack) begin
                        rb_push_cnt = fetch_bytes;
                        fetch_ip_d  = fetch_ip_q + 16'(fetch_bytes);
                        state_d     = PF_IDLE;
                    end
                end
                PF_ABORT: begin
                    if (mem_ack) begin
                        state_d = PF_IDLE;
                    end
                end
                default: state_d = PF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PF_IDLE;
            fetch_cs_q <= RESET_CS;
            fetch_ip_q <= RESET_IP;
            head_ip_q  <= RESET_IP;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_cs_q <= fetch_cs_d;
            fetch_ip_q <= fetch_ip_d;
            head_ip_q  <= head_ip_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    byte_ring_buffer #(.DEPTH(DEPTH)) u_ring (
        .clk       (clk),
        .rst_n     (reset),
        .flush     (rb_flush),
        .push_cnt  (rb_push_cnt),
        .push_dat0 (odd ? mem_data[15:8] : mem_data[7:0]),
        .push_dat1 (mem_data[15:8]),
        .pop_cnt   (rb_pop_cnt),
        .peek_dat0 (rd_data0),
        .peek_dat1 (rd_data1),
        .count     (count)
    );

    assign mem_access = (state_q != PF_IDLE);
    assign mem_addr   = mem_addr_q;
    assign head_ip    = head_ip_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: bus model with programmable ack delay and a byte scoreboard.
module tb_instr_prefetch_queue;

    localparam int DEPTH = 6;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_new_ip;
    logic [15:0]      new_cs, new_ip;
    logic [18:0]      mem_addr;
    logic             mem_access;
    logic             mem_ack;
    logic [15:0]      mem_data;
    logic [7:0]       rd_data0, rd_data1;
    logic [CNT_W-1:0] count;
    logic [1:0]       rd_count;
    logic [15:0]      head_ip;

    always #5 clk = ~clk;

    instr_prefetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_new_ip (load_new_ip),
        .new_cs      (new_cs),
        .new_ip      (new_ip),
        .mem_addr    (mem_addr),
        .mem_access  (mem_access),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .rd_data0    (rd_data0),
        .rd_data1    (rd_data1),
        .count       (count),
        .rd_count    (rd_count),
        .head_ip     (head_ip)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  sb[$];
    logic [15:0] m_cs, m_fip, m_head;
    bit          const_mode;
    int          ack_delay, wcnt;
    bit          prev_acc, stale;

    typedef struct {
        logic [15:0] cs;
        logic [15:0] ip;
        logic [1:0]  rc;
        int          fill;
        int          exp_count;
        logic [15:0] exp_head;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [19:0] phys(input logic [15:0] cs, input logic [15:0] ip);
        return {cs, 4'b0000} + {4'b0000, ip};
    endfunction

    function automatic logic [7:0] fbyte(input logic [19:0] p);
        return p[7:0] ^ p[15:8] ^ {4'h0, p[19:16]};
    endfunction

    function automatic logic [15:0] word_at(input logic [18:0] wa);
        if (const_mode) return 16'h3412;
        return {fbyte({wa, 1'b1}), fbyte({wa, 1'b0})};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs and bus response at negedge, update model, check after posedge.
    task automatic step(input logic ld, input logic [15:0] cs, input logic [15:0] ip, input logic [1:0] rc);
        int          rce, pop;
        logic [19:0] ep;
        logic [15:0] w;
        load_new_ip = ld;
        new_cs      = cs;
        new_ip      = ip;
        rd_count    = rc;
        mem_ack     = 1'b0;
        if (mem_access) begin
            if (!prev_acc) begin
                wcnt  = ack_delay;
                stale = 1'b0;
            end
            if (wcnt == 0) begin
                mem_ack  = 1'b1;
                mem_data = word_at(mem_addr);
            end else begin
                wcnt--;
            end
        end
        if (ld && mem_access) stale = 1'b1;
        rce = (rc == 2'd3) ? 2 : int'(rc);
        pop = (rce > sb.size()) ? sb.size() : rce;
        if (ld) begin
            sb.delete();
            m_cs   = cs;
            m_fip  = ip;
            m_head = ip;
        end else begin
            if (pop >= 1) chk("rd_data0", rd_data0, sb[0]);
            if (pop == 2) chk("rd_data1", rd_data1, sb[1]);
            for (int i = 0; i < pop; i++) void'(sb.pop_front());
            m_head = m_head + 16'(pop);
            if (mem_ack && !stale) begin
                ep = phys(m_cs, m_fip);
                chk("mem_addr", mem_addr, ep[19:1]);
                w = word_at(ep[19:1]);
                if (ep[0]) begin
                    sb.push_back(w[15:8]);
                    m_fip = m_fip + 16'd1;
                end else begin
                    sb.push_back(w[7:0]);
                    sb.push_back(w[15:8]);
                    m_fip = m_fip + 16'd2;
                end
            end
        end
        prev_acc = mem_access;
        @(posedge clk);
        #1;
        chk("count", count, sb.size());
        chk("head_ip", head_ip, m_head);
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{16'h0000, 16'h0010, 2'd0, 6, 6, 16'h0010};
        tbl[1] = '{16'h0000, 16'h0010, 2'd1, 6, 5, 16'h0011};
        tbl[2] = '{16'h0000, 16'h0010, 2'd2, 6, 4, 16'h0012};
        tbl[3] = '{16'h0000, 16'h0010, 2'd3, 6, 4, 16'h0012};
        tbl[4] = '{16'h0000, 16'hFFFD, 2'd2, 5, 3, 16'hFFFF};
        tbl[5] = '{16'h1234, 16'h0005, 2'd1, 5, 4, 16'h0006};
        tbl[6] = '{16'hF000, 16'hFFFF, 2'd3, 5, 3, 16'h0001};

        reset = 1'b0; load_new_ip = 1'b0; new_cs = '0; new_ip = '0;
        rd_count = '0; mem_ack = 1'b0; mem_data = '0;
        const_mode = 1'b1; ack_delay = 0; wcnt = 0; prev_acc = 1'b0; stale = 1'b0;
        m_cs = 16'hFFFF; m_fip = 16'h0000; m_head = 16'h0000;

        #12;
        chk("rst_count", count, 0);
        chk("rst_mem_access", mem_access, 0);
        chk("rst_head_ip", head_ip, 16'h0000);
        chk("rst_rd_data0", rd_data0, 8'h00);
        chk("rst_rd_data1", rd_data1, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        // Free-running bus, constant data, no pops: queue fills then fetching stops.
        step(1'b0, 16'h0, 16'h0, 2'd0);
        chk("first_access", mem_access, 1);
        chk("first_addr", mem_addr, 19'h7FFF8);
        repeat (10) step(1'b0, 16'h0, 16'h0, 2'd0);
        chk("full_count", count, 6);
        chk("full_idle", mem_access, 0);
        chk("full_rd0", rd_data0, 8'h12);
        chk("full_rd1", rd_data1, 8'h34);
        chk("full_head", head_ip, 16'h0000);

        // Odd-address redirect, then pop 2 while count=1 as an even word lands.
        const_mode = 1'b0;
        step(1'b1, 16'h1000, 16'h0003, 2'd0);
        step(1'b0, 16'h0, 16'h0, 2'd0);
        chk("odd_addr", mem_addr, 19'h08001);
        step(1'b0, 16'h0, 16'h0, 2'd0);
        chk("odd_count", count, 1);
        chk("odd_rd0", rd_data0, fbyte(20'h10003));
        step(1'b0, 16'h0, 16'h0, 2'd0);
        chk("even_addr", mem_addr, 19'h08002);
        step(1'b0, 16'h0, 16'h0, 2'd2);
        chk("pushpop_count", count, 2);
        chk("pushpop_head", head_ip, 16'h0004);
        chk("pushpop_rd0", rd_data0, fbyte(20'h10004));

        // Redirect while the bus is slow: access held, word dropped, then new address.
        ack_delay = 3;
        for (int i = 0; i < 10 && !mem_access; i++) step(1'b0, 16'h0, 16'h0, 2'd0);
        chk("abort_start", mem_access, 1);
        step(1'b1, 16'h2000, 16'h0100, 2'd0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_held", mem_access, 1);
            step(1'b0, 16'h0, 16'h0, 2'd0);
        end
        ack_delay = 0;
        step(1'b0, 16'h0, 16'h0, 2'd0);
        chk("abort_new_access", mem_access, 1);
        chk("abort_new_addr", mem_addr, 19'h10080);
        repeat (4) step(1'b0, 16'h0, 16'h0, 2'd0);

        // Segment wrap of fetch IP and head IP.
        step(1'b1, 16'h0000, 16'hFFFE, 2'd0);
        step(1'b0, 16'h0, 16'h0, 2'd0);
        chk("wrap_addr0", mem_addr, 19'h07FFF);
        step(1'b0, 16'h0, 16'h0, 2'd0);
        step(1'b0, 16'h0, 16'h0, 2'd0);
        chk("wrap_addr1", mem_addr, 19'h00000);
        step(1'b0, 16'h0, 16'h0, 2'd1);
        step(1'b0, 16'h0, 16'h0, 2'd1);
        chk("wrap_head", head_ip, 16'h0000);

        // Table: fill from a start address, one pop of rc, check occupancy and head.
        foreach (tbl[k]) begin
            step(1'b1, tbl[k].cs, tbl[k].ip, 2'd0);
            repeat (12) step(1'b0, 16'h0, 16'h0, 2'd0);
            chk("tbl_fill", count, tbl[k].fill);
            step(1'b0, 16'h0, 16'h0, tbl[k].rc);
            chk("tbl_count", count, tbl[k].exp_count);
            chk("tbl_head", head_ip, tbl[k].exp_head);
            chk("tbl_rd0", rd_data0, fbyte(phys(tbl[k].cs, tbl[k].exp_head)));
        end

        // Random pops, ack delays and occasional redirects against the scoreboard.
        step(1'b1, 16'($urandom), 16'($urandom), 2'd0);
        for (int n = 0; n < 3000; n++) begin
            ack_delay = $urandom_range(0, 2);
            step(($urandom_range(0, 99) == 0), 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
            if (n % 100 == 0) chk("count_le_depth", (count <= CNT_W'(DEPTH)), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
